wb_shared_bus_arbiter: RTL and testbench

//  - Shares one Wishbone slave-side bus among N_MASTERS masters.
//  - Performs round-robin arbitration on cyc and holds the grant for the owner's whole cycle (bus lock).
//  - Muxes owner's adr/dat/sel/we/stb onto the slave bus; returns ack/err only to the owner.
//  - Sits between the CPU/DMA masters and the slave-side address decoder; it is the full-mux successor of the cyc-only arbiter.

---
 rtl/wb_arb_pkg.sv | 35 +++
 rtl/wb_rr_picker.sv | 17 +
 rtl/wb_shared_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_shared_bus_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the Wishbone shared-bus arbiter.
package wb_arb_pkg;

  localparam int unsigned MAX_MASTERS = 8;
  localparam int unsigned PTR_W       = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  typedef logic [MAX_MASTERS-1:0] mvec_t;

  // Round-robin pick: first requester scanning last+1, last+2, ... modulo n; one-hot result.
  function automatic mvec_t rr_pick(input mvec_t req, input logic [PTR_W-1:0] last,
                                    input int unsigned n);
    mvec_t       pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= MAX_MASTERS; i++) begin
      if (i <= n) begin
        idx = (32'(last) + i) % n;
        if (!found && req[idx[PTR_W-1:0]]) begin
          pick[idx[PTR_W-1:0]] = 1'b1;
          found                = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin priority encoder: request vector and last owner to one-hot pick.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS = 4,
  parameter int unsigned LW        = 2
) (
  input  logic [N_MASTERS-1:0] req,
  input  logic [LW-1:0]        last,
  output logic [N_MASTERS-1:0] pick,
  output logic                 valid
);

  assign pick  = N_MASTERS'(rr_pick(MAX_MASTERS'(req), PTR_W'(last), N_MASTERS));
  assign valid = |req;

endmodule

// File: rtl/wb_shared_bus_arbiter.sv
// Wishbone shared-bus arbiter: round-robin grant on cyc, bus lock for the owner's
// whole cycle, full mux of the owner onto the slave side.
// Optional watchdog error injection is enabled with macro WB_ARB_TIMEOUT_EN.
module wb_shared_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned N_MASTERS      = 4,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned SW            = DW / 8,
  localparam int unsigned LW            = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_MASTERS-1:0]    m_cyc_i,
  input  logic [N_MASTERS-1:0]    m_stb_i,
  input  logic [N_MASTERS-1:0]    m_we_i,
  input  logic [N_MASTERS*AW-1:0] m_adr_i,
  input  logic [N_MASTERS*DW-1:0] m_dat_i,
  input  logic [N_MASTERS*SW-1:0] m_sel_i,
  output logic [DW-1:0]           m_dat_o,
  output logic [N_MASTERS-1:0]    m_ack_o,
  output logic [N_MASTERS-1:0]    m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [SW-1:0]           s_sel_o,
  input  logic [DW-1:0]           s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  output logic [N_MASTERS-1:0]    gnt_o,
  output logic                    busy_o
);

  // Reject unsupported configurations at elaboration.
  if (N_MASTERS < 2 || N_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES == 0 || (DW % 8) != 0)
  begin : g_bad_param
    $error("wb_shared_bus_arbiter: unsupported parameter set");
  end

  state_t                state_q, state_d;
  logic [N_MASTERS-1:0]  gnt_q, gnt_d;
  logic [LW-1:0]         last_q, last_d;
  logic [LW-1:0]         own;
  logic [LW-1:0]         pick_idx;
  logic [N_MASTERS-1:0]  pick;
  logic                  pick_valid;
  logic                  wdog_err;

  wb_rr_picker #(
    .N_MASTERS (N_MASTERS),
    .LW        (LW)
  ) u_picker (
    .req   (m_cyc_i),
    .last  (last_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // Binary index of the current owner and of the candidate pick.
  always_comb begin
    own      = '0;
    pick_idx = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (gnt_q[i]) own = LW'(i);
      if (pick[i])  pick_idx = LW'(i);
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(N_MASTERS - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Next state: grant from IDLE, hold the lock until the owner drops cyc.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWNED;
          gnt_d   = pick;
          last_d  = pick_idx;
        end
      end
      ST_OWNED: begin
        if (!m_cyc_i[own]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Slave-side mux and owner-only response routing; everything quiet while idle.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state_q == ST_OWNED) begin
      s_cyc_o      = m_cyc_i[own];
      s_stb_o      = m_stb_i[own];
      s_we_o       = m_we_i[own];
      s_adr_o      = m_adr_i[32'(own)*AW +: AW];
      s_dat_o      = m_dat_i[32'(own)*DW +: DW];
      s_sel_o      = m_sel_i[32'(own)*SW +: SW];
      m_ack_o[own] = s_ack_i & m_cyc_i[own];
      m_err_o[own] = (s_err_i | wdog_err) & m_cyc_i[own];
    end
  end

  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q == ST_OWNED);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned WDW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [WDW-1:0] wdog_q;
  logic           wdog_err_q;
  logic           stall;

  assign stall = (state_q == ST_OWNED) && s_stb_o && !s_ack_i && !s_err_i;

  // Watchdog: count stalled strobe cycles, pulse an error at the limit and restart.
  always_ff @(posedge clk) begin
    if (!rst_n || state_q != ST_OWNED || state_d != ST_OWNED) begin
      wdog_q     <= '0;
      wdog_err_q <= 1'b0;
    end else if (stall) begin
      if (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) begin
        wdog_q     <= '0;
        wdog_err_q <= 1'b1;
      end else begin
        wdog_q     <= wdog_q + WDW'(1);
        wdog_err_q <= 1'b0;
      end
    end else begin
      if (s_ack_i || s_err_i) wdog_q <= '0;
      wdog_err_q <= 1'b0;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_shared_bus_arbiter.sv
// Directed bench for wb_shared_bus_arbiter (4 masters, 32-bit bus, timeout 16).
module tb_wb_shared_bus_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*DW-1:0] m_dat_i;
  logic [N*SW-1:0] m_sel_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_i;
  logic            s_ack_i, s_err_i;
  logic [N-1:0]    gnt_o;
  logic            busy_o;

  int total = 0;
  int bad   = 0;
  int pulses;

  wb_shared_bus_arbiter #(
    .N_MASTERS      (N),
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .s_err_i (s_err_i),
    .gnt_o   (gnt_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    s_dat_i = '0;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_busy", 64'(busy_o), 64'h0);
    check("rst_scyc", 64'(s_cyc_o), 64'h0);
    check("rst_ack", 64'(m_ack_o), 64'h0);
    check("rst_err", 64'(m_err_o), 64'h0);
    s_dat_i = 32'h1234_5678;
    #1;
    check("rst_mdat", 64'(m_dat_o), 64'h1234_5678);

    for (int k = 0; k < 4; k++) begin
      m_adr_i[k*32 +: 32] = 32'(k) * 32'h1000;
      m_dat_i[k*32 +: 32] = 32'hA000_0000 + 32'(k);
      m_sel_i[k*4 +: 4]   = 4'b0001 << k;
    end

    // round robin with all masters requesting
    rst_n   = 1'b1;
    m_cyc_i = 4'b1111;
    m_stb_i = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("rr_gnt", 64'(gnt_o), 64'(4'b0001 << k));
      check("rr_busy", 64'(busy_o), 64'h1);
      check("rr_scyc", 64'(s_cyc_o), 64'h1);
      check("rr_sadr", 64'(s_adr_o), 64'(32'(k) * 32'h1000));
      check("rr_ssel", 64'(s_sel_o), 64'(4'b0001 << k));
      s_ack_i = 1'b1;
      #1;
      check("rr_ack", 64'(m_ack_o), 64'(4'b0001 << k));
      tick();
      s_ack_i    = 1'b0;
      m_cyc_i[k] = 1'b0;
      m_stb_i[k] = 1'b0;
      #1;
      check("rr_drop_scyc", 64'(s_cyc_o), 64'h0);
      tick();
      check("rr_dead_gnt", 64'(gnt_o), 64'h0);
      check("rr_dead_busy", 64'(busy_o), 64'h0);
      tick();
    end

    // lock: master 1 keeps the bus for three beats while master 0 waits
    m_cyc_i = 4'b0010;
    m_stb_i = 4'b0010;
    tick();
    check("lock_gnt", 64'(gnt_o), 64'h2);
    m_cyc_i[0] = 1'b1;
    m_stb_i[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_ack_i = 1'b1;
      #1;
      check("lock_ack", 64'(m_ack_o), 64'h2);
      tick();
      check("lock_hold", 64'(gnt_o), 64'h2);
    end
    s_ack_i    = 1'b0;
    m_cyc_i[1] = 1'b0;
    m_stb_i[1] = 1'b0;
    tick();
    check("lock_dead", 64'(gnt_o), 64'h0);
    tick();
    check("lock_next", 64'(gnt_o), 64'h1);
    m_cyc_i = '0;
    m_stb_i = '0;
    tick();

    // routing with owner 2
    m_cyc_i = 4'b0100;
    m_stb_i = 4'b0100;
    m_we_i  = 4'b0100;
    tick();
    check("route_gnt", 64'(gnt_o), 64'h4);
    s_ack_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("route_ack", 64'(m_ack_o), 64'h4);
    check("route_mdat", 64'(m_dat_o), 64'hDEAD_BEEF);
    check("route_sadr", 64'(s_adr_o), 64'h0000_2000);
    check("route_swe", 64'(s_we_o), 64'h1);
    check("route_sdat", 64'(s_dat_o), 64'hA000_0002);
    m_cyc_i = '0;
    m_stb_i = '0;
    #1;
    check("drop_ack_discard", 64'(m_ack_o), 64'h0);
    tick();
    s_ack_i = 1'b0;
    m_we_i  = '0;
    check("route_release", 64'(gnt_o), 64'h0);

    // slave error with owner 3
    m_cyc_i = 4'b1000;
    m_stb_i = 4'b1000;
    tick();
    check("err_gnt", 64'(gnt_o), 64'h8);
    s_err_i = 1'b1;
    #1;
    check("err_route", 64'(m_err_o), 64'h8);
    check("err_noack", 64'(m_ack_o), 64'h0);
    s_err_i = 1'b0;
    m_cyc_i = '0;
    m_stb_i = '0;
    tick();
    check("err_release", 64'(gnt_o), 64'h0);

    // simultaneous requests after owner 3: master 0 first, then master 3
    m_cyc_i = 4'b1001;
    m_stb_i = 4'b1001;
    tick();
    check("sim_first", 64'(gnt_o), 64'h1);
    m_cyc_i = 4'b1000;
    m_stb_i = 4'b1000;
    tick();
    check("sim_dead", 64'(gnt_o), 64'h0);
    m_cyc_i = 4'b1001;
    m_stb_i = 4'b1001;
    tick();
    check("sim_second", 64'(gnt_o), 64'h8);
    m_cyc_i = '0;
    m_stb_i = '0;
    tick();
    tick();

    // reset mid-transfer
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    tick();
    check("mid_gnt", 64'(gnt_o), 64'h1);
    check("mid_sstb", 64'(s_stb_o), 64'h1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_gnt", 64'(gnt_o), 64'h0);
    check("mid_rst_scyc", 64'(s_cyc_o), 64'h0);
    check("mid_rst_busy", 64'(busy_o), 64'h0);
    rst_n   = 1'b1;
    m_cyc_i = 4'b0011;
    m_stb_i = 4'b0011;
    tick();
    check("rst_ptr", 64'(gnt_o), 64'h1);
    m_cyc_i = '0;
    m_stb_i = '0;
    tick();
    tick();

    // stalled owner 0: watchdog pulses only when enabled
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    tick();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_err_o != 4'b0000) pulses++;
      tick();
    end
`ifdef WB_ARB_TIMEOUT_EN
    check("wdog_first", 64'(pulses), 64'd1);
`else
    check("wdog_first", 64'(pulses), 64'd0);
`endif
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_err_o != 4'b0000) pulses++;
      tick();
    end
`ifdef WB_ARB_TIMEOUT_EN
    check("wdog_restart", 64'(pulses), 64'd1);
`else
    check("wdog_restart", 64'(pulses), 64'd0);
`endif
    check("wdog_keep_gnt", 64'(gnt_o), 64'h1);
    m_cyc_i = '0;
    m_stb_i = '0;
    tick();
    check("wdog_release", 64'(gnt_o), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
